// File: rtl/sti_load_arbiter.sv
// sti_load_arbiter: round-robin arbiter that shares one serial transmitter
// among NREQ word producers, issues a one-cycle load per word, follows
// so_valid until the word is shifted out and checks the shifted bit count.
module sti_load_arbiter #(
  parameter int NREQ   = 4,
  parameter int TO_CYC = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [16*NREQ-1:0]  req_data,
  input  logic [2*NREQ-1:0]   req_length,
  input  logic [3*NREQ-1:0]   req_cfg,
  input  logic [NREQ-1:0]     req_last,
  input  logic                so_valid,
  output logic [NREQ-1:0]     gnt,
  output logic                load,
  output logic [15:0]         pi_data,
  output logic [1:0]          pi_length,
  output logic                pi_fill,
  output logic                pi_msb,
  output logic                pi_low,
  output logic                pi_end,
  output logic                busy,
  output logic                err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TO_CYC + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WSTART = 3'd2;
  localparam logic [2:0] S_WDONE  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_END    = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [IW-1:0]   rrPtr_q, rrPtr_d;
  logic [NREQ-1:0] doneMask_q, doneMask_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic            lastR_q, lastR_d;
  logic [15:0]     piData_q, piData_d;
  logic [1:0]      piLength_q, piLength_d;
  logic [2:0]      piCfg_q, piCfg_d;
  logic [5:0]      bitCnt_q, bitCnt_d;
  logic [TW-1:0]   toCnt_q, toCnt_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] eligible;
  logic            pickValid;
  logic [IW-1:0]   pickIdx;
  logic [5:0]      expBits;

  // Index base+off wrapped modulo NREQ (off is always below NREQ).
  function automatic logic [IW-1:0] wrapIdx(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  assign eligible = req & ~doneMask_q;
  assign expBits  = ({4'b0000, piLength_q} + 6'd1) << 3;

  // Round-robin pick: scan downwards so the smallest offset from rrPtr wins.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (eligible[wrapIdx(rrPtr_q, i)]) begin
        pickValid = 1'b1;
        pickIdx   = wrapIdx(rrPtr_q, i);
      end
    end
  end

  // Next-state logic for the arbitration / word-tracking sequence.
  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    doneMask_d = doneMask_q;
    sel_d      = sel_q;
    lastR_d    = lastR_q;
    piData_d   = piData_q;
    piLength_d = piLength_q;
    piCfg_d    = piCfg_q;
    bitCnt_d   = bitCnt_q;
    toCnt_d    = toCnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (&doneMask_q) begin
          state_d = S_END;
        end else if (pickValid) begin
          sel_d      = pickIdx;
          piData_d   = req_data[16*int'(pickIdx) +: 16];
          piLength_d = req_length[2*int'(pickIdx) +: 2];
          piCfg_d    = req_cfg[3*int'(pickIdx) +: 3];
          lastR_d    = req_last[pickIdx];
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        rrPtr_d = (sel_q == IW'(NREQ - 1)) ? '0 : sel_q + IW'(1);
        if (lastR_q) doneMask_d[sel_q] = 1'b1;
        state_d = S_WSTART;
      end
      S_WSTART: begin
        toCnt_d = toCnt_q + TW'(1);
        if (so_valid) begin
          bitCnt_d = 6'd1;
          state_d  = S_WDONE;
        end else if (toCnt_q == TW'(TO_CYC - 1)) begin
          err_d   = 1'b1;
          state_d = S_GAP;
        end
      end
      S_WDONE: begin
        if (so_valid) begin
          if (bitCnt_q != 6'h3F) bitCnt_d = bitCnt_q + 6'd1;
        end else begin
          if (bitCnt_q != expBits) err_d = 1'b1;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        toCnt_d  = '0;
        bitCnt_d = '0;
        state_d  = S_IDLE;
      end
      S_END: begin
        state_d = S_END;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-word registers, cleared asynchronously by reset low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rrPtr_q    <= '0;
      doneMask_q <= '0;
      sel_q      <= '0;
      lastR_q    <= 1'b0;
      piData_q   <= '0;
      piLength_q <= '0;
      piCfg_q    <= '0;
      bitCnt_q   <= '0;
      toCnt_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      doneMask_q <= doneMask_d;
      sel_q      <= sel_d;
      lastR_q    <= lastR_d;
      piData_q   <= piData_d;
      piLength_q <= piLength_d;
      piCfg_q    <= piCfg_d;
      bitCnt_q   <= bitCnt_d;
      toCnt_q    <= toCnt_d;
      err_q      <= err_d;
    end
  end

  assign load      = (state_q == S_LOAD);
  assign gnt       = load ? ({{(NREQ-1){1'b0}}, 1'b1} << sel_q) : '0;
  assign pi_data   = piData_q;
  assign pi_length = piLength_q;
  assign pi_fill   = piCfg_q[2];
  assign pi_msb    = piCfg_q[1];
  assign pi_low    = piCfg_q[0];
  assign pi_end    = (state_q == S_END);
  assign busy      = (state_q == S_LOAD) || (state_q == S_WSTART) ||
                     (state_q == S_WDONE) || (state_q == S_GAP);
  assign err       = err_q;

endmodule

// File: tb/tb_sti_load_arbiter.sv
// Self-checking bench for sti_load_arbiter: vector table, corner-case
// sequences and a randomized run against a round-robin reference model.
module tb_sti_load_arbiter;

  localparam int NREQ   = 4;
  localparam int TO_CYC = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [16*NREQ-1:0] req_data;
  logic [2*NREQ-1:0] req_length;
  logic [3*NREQ-1:0] req_cfg;
  logic [NREQ-1:0]   req_last;
  logic              so_valid;
  logic [NREQ-1:0]   gnt;
  logic              load;
  logic [15:0]       pi_data;
  logic [1:0]        pi_length;
  logic              pi_fill, pi_msb, pi_low, pi_end, busy, err;

  sti_load_arbiter #(.NREQ(NREQ), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data),
    .req_length(req_length), .req_cfg(req_cfg), .req_last(req_last),
    .so_valid(so_valid), .gnt(gnt), .load(load), .pi_data(pi_data),
    .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb),
    .pi_low(pi_low), .pi_end(pi_end), .busy(busy), .err(err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] reqMask;
    logic [3:0] lastMask;
    int         expIdx;
  } vecT;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int onCycle = 0;
  int offCycle = 0;
  int svOverride = -1;
  int prevLoad = -1000;
  int prevBits = 0;
  logic [15:0] reqDataArr [NREQ];
  logic [1:0]  reqLenArr  [NREQ];
  logic [2:0]  reqCfgArr  [NREQ];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; also plays the transmitter: so_valid rises two cycles after
  // load and stays high for the word's bit count (or svOverride cycles).
  task automatic tick();
    logic loadNow;
    int bits;
    loadNow = load;
    bits = (svOverride >= 0) ? svOverride : 8 * (int'(pi_length) + 1);
    @(posedge clk);
    #1;
    cycle++;
    if (loadNow === 1'b1) begin
      onCycle  = cycle + 1;
      offCycle = onCycle + bits;
    end
    so_valid = (cycle >= onCycle) && (cycle < offCycle);
  endtask

  task automatic applyStimulus(input logic [3:0] reqMask, input logic [3:0] lastMask);
    req      = reqMask;
    req_last = lastMask;
    for (int k = 0; k < NREQ; k++) begin
      req_data[16*k +: 16] = reqDataArr[k];
      req_length[2*k +: 2] = reqLenArr[k];
      req_cfg[3*k +: 3]    = reqCfgArr[k];
    end
  endtask

  task automatic setDefaults();
    for (int k = 0; k < NREQ; k++) begin
      reqDataArr[k] = 16'h1111 * 16'(k + 1);
      reqLenArr[k]  = 2'(k);
      reqCfgArr[k]  = 3'(k + 1);
    end
  endtask

  task automatic applyReset();
    reset = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    so_valid   = 1'b0;
    onCycle    = 0;
    offCycle   = 0;
    svOverride = -1;
    prevLoad   = -1000;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic waitLoad(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (load === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitIdle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput({tag, ".idle"}, 32'(done), 32'd1);
  endtask

  // One request round: expect a grant to expIdx (or none if negative),
  // check the presented word and the error flag once the word is out.
  task automatic doTxn(input logic [3:0] reqMask, input logic [3:0] lastMask,
                       input int expIdx, input logic expErr, input string tag);
    bit seen;
    int loads;
    logic [3:0] expGnt;
    applyStimulus(reqMask, lastMask);
    if (expIdx < 0) begin
      loads = 0;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (load === 1'b1) loads++;
      end
      applyStimulus(4'b0000, 4'b0000);
      checkOutput({tag, ".noLoad"}, 32'(loads), 32'd0);
      return;
    end
    waitLoad(seen);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput({tag, ".load"}, 32'(seen), 32'd1);
    if (!seen) return;
    expGnt = 4'b0001 << expIdx;
    checkOutput({tag, ".gnt"}, 32'(gnt), 32'(expGnt));
    checkOutput({tag, ".data"}, 32'(pi_data), 32'(reqDataArr[expIdx]));
    checkOutput({tag, ".len"}, 32'(pi_length), 32'(reqLenArr[expIdx]));
    checkOutput({tag, ".cfg"}, 32'({pi_fill, pi_msb, pi_low}), 32'(reqCfgArr[expIdx]));
    checkOutput({tag, ".spacing"}, 32'(cycle - prevLoad >= prevBits + 4), 32'd1);
    prevLoad = cycle;
    prevBits = 8 * (int'(reqLenArr[expIdx]) + 1);
    waitIdle(tag);
    checkOutput({tag, ".err"}, 32'(err), 32'(expErr));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    vecT tbl [11];
    bit seen;
    int waited;
    int rr;
    int g;
    int j;
    logic [3:0] done;
    logic [3:0] mask;
    logic [3:0] lastM;
    logic [3:0] elig;

    tbl[0]  = '{4'b1111, 4'b0000, 0};
    tbl[1]  = '{4'b1111, 4'b0000, 1};
    tbl[2]  = '{4'b1111, 4'b0000, 2};
    tbl[3]  = '{4'b1111, 4'b0000, 3};
    tbl[4]  = '{4'b1111, 4'b0000, 0};
    tbl[5]  = '{4'b0100, 4'b0000, 2};
    tbl[6]  = '{4'b1001, 4'b0000, 3};
    tbl[7]  = '{4'b1001, 4'b0000, 0};
    tbl[8]  = '{4'b1001, 4'b0000, 3};
    tbl[9]  = '{4'b0010, 4'b0000, 1};
    tbl[10] = '{4'b0011, 4'b0000, 0};

    setDefaults();
    reset = 1'b0;
    so_valid = 1'b0;
    applyStimulus(4'b0000, 4'b0000);
    #3;
    checkOutput("rst.load", 32'(load), 32'd0);
    checkOutput("rst.gnt", 32'(gnt), 32'd0);
    checkOutput("rst.data", 32'(pi_data), 32'd0);
    checkOutput("rst.end", 32'(pi_end), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'd0);
    checkOutput("rst.err", 32'(err), 32'd0);
    applyReset();

    // Vector table: round-robin order and wrap-around.
    for (int v = 0; v < 11; v++) begin
      doTxn(tbl[v].reqMask, tbl[v].lastMask, tbl[v].expIdx, 1'b0, $sformatf("vec%0d", v));
    end

    // Every requester finishes; requester 0 sends the final word 00A5.
    applyReset();
    doTxn(4'b0010, 4'b0010, 1, 1'b0, "fin1");
    doTxn(4'b0100, 4'b0100, 2, 1'b0, "fin2");
    doTxn(4'b1000, 4'b1000, 3, 1'b0, "fin3");
    reqDataArr[0] = 16'h00A5;
    reqLenArr[0]  = 2'd0;
    reqCfgArr[0]  = 3'b010;
    doTxn(4'b0001, 4'b0001, 0, 1'b0, "fin0");
    checkOutput("fin.endEarly", 32'(pi_end), 32'd0);
    tick();
    checkOutput("fin.end", 32'(pi_end), 32'd1);
    checkOutput("fin.busy", 32'(busy), 32'd0);
    doTxn(4'b1111, 4'b0000, -1, 1'b0, "finHold");
    checkOutput("fin.endSticky", 32'(pi_end), 32'd1);
    setDefaults();

    // Bit-count mismatch: 32-bit word shifted for only 31 cycles.
    applyReset();
    reqLenArr[2] = 2'd3;
    svOverride = 31;
    checkOutput("lenMis.errBefore", 32'(err), 32'd0);
    doTxn(4'b0100, 4'b0000, 2, 1'b1, "lenMis");
    svOverride = -1;
    doTxn(4'b0010, 4'b0000, 1, 1'b1, "lenNext");
    setDefaults();

    // Timeout: so_valid never rises after load.
    applyReset();
    svOverride = 0;
    applyStimulus(4'b0001, 4'b0000);
    waitLoad(seen);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("to.load", 32'(seen), 32'd1);
    waited = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (err === 1'b1) begin
        waited = i;
        break;
      end
    end
    checkOutput("to.errCycle", 32'(waited), 32'd9);
    checkOutput("to.gapBusy", 32'(busy), 32'd1);
    waitIdle("to");
    svOverride = -1;
    doTxn(4'b1000, 4'b0000, 3, 1'b1, "toNext");

    // Reset pulled low while a word is being shifted out.
    applyReset();
    doTxn(4'b0001, 4'b0000, 0, 1'b0, "rstPre");
    applyStimulus(4'b0110, 4'b0000);
    waitLoad(seen);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("rstMid.gnt", 32'(gnt), 32'h2);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("rstMid.busyBefore", 32'(busy & so_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rstMid.load", 32'(load), 32'd0);
    checkOutput("rstMid.gnt0", 32'(gnt), 32'd0);
    checkOutput("rstMid.pi", 32'({pi_data, pi_length, pi_fill, pi_msb, pi_low}), 32'd0);
    checkOutput("rstMid.end", 32'(pi_end), 32'd0);
    checkOutput("rstMid.busy", 32'(busy), 32'd0);
    checkOutput("rstMid.err", 32'(err), 32'd0);
    applyReset();
    doTxn(4'b1111, 4'b0000, 0, 1'b0, "rstRecover");

    // Randomized run against a round-robin reference model.
    applyReset();
    rr = 0;
    done = 4'b0000;
    for (int it = 0; it < 60; it++) begin
      if (done == 4'hF) begin
        tick();
        checkOutput("rnd.end", 32'(pi_end), 32'd1);
        checkOutput("rnd.endBusy", 32'(busy), 32'd0);
        applyReset();
        rr = 0;
        done = 4'b0000;
        continue;
      end
      for (int k = 0; k < NREQ; k++) begin
        reqDataArr[k] = 16'($urandom);
        reqLenArr[k]  = 2'($urandom_range(0, 3));
        reqCfgArr[k]  = 3'($urandom_range(0, 7));
      end
      mask = 4'($urandom_range(0, 15));
      lastM = 4'b0000;
      for (int k = 0; k < NREQ; k++) lastM[k] = ($urandom_range(0, 4) == 0);
      elig = mask & ~done;
      g = -1;
      for (int i = 0; i < NREQ; i++) begin
        j = (rr + i) % NREQ;
        if (elig[j]) begin
          g = j;
          break;
        end
      end
      doTxn(mask, lastM, g, 1'b0, $sformatf("rnd%0d", it));
      if (g >= 0) begin
        rr = (g + 1) % NREQ;
        if (lastM[g]) done[g] = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sti_load_arbiter.md
Name: sti_load_arbiter

Overview:
- Round-robin scheduler that shares one serial transmitter / data-arrange controller among NREQ word producers.
- Picks one pending request and presents its word and format controls on the pi_* bus. Issues a one-cycle load, then tracks so_valid until the word has been shifted out.
- When every requester has signalled its last word, asserts pi_end.
- Sits between producer blocks and the transmitter; also checks the transmitted bit count.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TO_CYC, 8, max cycles from load to so_valid rising before a timeout is flagged.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets all state immediately).
- req  in  NREQ  per-requester word pending; level, held until its gnt.
- req_data  in  16*NREQ  word of requester k at [16k+15:16k].
- req_length  in  2*NREQ  length code: 0=8, 1=16, 2=24, 3=32 bits.
- req_cfg  in  3*NREQ  {fill,msb,low} of requester k at [3k+2:3k].
- req_last  in  NREQ  qualifies req: this word is the requester's final one.
- so_valid  in  1  from transmitter; high while serial bits are output.
- gnt  out  NREQ  one-hot, one-cycle pulse coincident with load.
- load  out  1  one-cycle load strobe to transmitter.
- pi_data  out  16  registered word.
- pi_length  out  2  registered length code.
- pi_fill  out  1  registered.
- pi_msb  out  1  registered.
- pi_low  out  1  registered.
- pi_end  out  1  all requesters finished; sticky.
- busy  out  1  high in any state but IDLE/END.
- err  out  1  sticky: timeout or bit-count mismatch.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, done_mask=0, bitcnt=0, to_cnt=0. All outputs 0.
- States: IDLE, LOAD, WSTART, WDONE, GAP, END.
- IDLE:
  - If done_mask is all ones -> END.
  - Else eligible = req & ~done_mask. If eligible!=0, pick the first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Capture that requester's data/length/cfg/last into pi_* and the internal last_r; then -> LOAD.
  - With no eligible requests, stay in IDLE.
- LOAD (exactly 1 cycle): load=1, gnt[k]=1.
  - rr_ptr <= (k+1) mod NREQ.
  - If last_r, set done_mask[k].
  - -> WSTART.
- pi_* outputs change only on the IDLE capture edge. They are held constant from LOAD until the next capture, because the transmitter samples them the cycle after load.
- WSTART:
  - to_cnt increments each cycle.
  - On so_valid=1: bitcnt<=1 -> WDONE.
  - If to_cnt reaches TO_CYC with no so_valid: err<=1 -> GAP.
  - Nominal latency from load to so_valid is 2 cycles.
- WDONE:
  - While so_valid=1, bitcnt++.
  - On so_valid=0: compare bitcnt with 8*(pi_length+1). On mismatch, err<=1. Then -> GAP.
  - bitcnt is 6 bits wide and saturates at 63.
- GAP (1 cycle): lets the transmitter return to its idle state. to_cnt and bitcnt are cleared. -> IDLE.
- Minimum spacing between load pulses is 2+N+2 cycles, where N is the word bit count.
- END: pi_end=1, busy=0. Terminal; load and gnt are never asserted again until reset.
- req_last is sampled only at capture. Requests from requesters already in done_mask are ignored.
- A new req arriving while busy waits until the next IDLE. Simultaneous requests are resolved strictly by rr_ptr.
- A req withdrawn before its grant is legal; it is simply not selected.
- busy = state in {LOAD, WSTART, WDONE, GAP}.
- Reset asserted mid-word: everything clears asynchronously; any transmitter activity in progress is ignored.

Test Plan:
- Single requester 0, length=0, data=16'h00A5, last=1; so_valid modelled high 8 cycles starting 2 cycles after load. Required: load and gnt=0001 pulse together, pi_data=16'h00A5, err=0, pi_end=1 two cycles after GAP, busy=0.
- req=1111 all asserted, none last. Required: grant order 0,1,2,3,0, each gnt one-hot. Load pulses separated by at least N+4 cycles.
- rr wrap: after a grant to 3 with req=1001 asserted, the next grant is 0, then 3.
- Length=3 with so_valid high for only 31 cycles. Required: err=1 after so_valid falls; arbitration continues.
- so_valid never rises after load, TO_CYC=8. Required: err=1 at cycle 8 of WSTART, then GAP, IDLE, and the next request is granted.
- Reset pulled low during WDONE. Required: load, gnt, pi_*, pi_end, busy and err all 0 immediately; after release the first grant goes to requester 0.
